sync_fifo_ex: RTL and testbench
===============================

Name: sync_fifo_ex

Overview:
- Single-clock, parametrised FIFO for same-domain buffering: command queues and data staging between the cartridge bus logic and the SDRAM and MCU links.
- Generalises the team's dual-clock FIFO as follows:
  - DEPTH is arbitrary; it need not be a power of two.
  - Exact fill level is exported.
  - Almost-full and almost-empty thresholds are programmable.
  - Synchronous flush is supported.
  - Overflow and underflow error flags are sticky.
  - Read port is selectable between show-ahead and registered mode.

Parameters:
- DEPTH, 8: number of entries; must be at least 2; any integer is allowed.
- DATA_WIDTH, 16: word width in bits.
- SHOWAHEAD, 1: 1 selects first-word-fall-through reads; 0 selects registered reads with rd_valid.
- AF_LEVEL, DEPTH-1: almost_full asserts when level >= AF_LEVEL; valid range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when level <= AE_LEVEL; valid range 0..DEPTH-1.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous clear of FIFO contents.
- wr_data, input, DATA_WIDTH: write word.
- wr_en, input, 1: write request.
- full, output, 1: no free entry.
- almost_full, output, 1: level >= AF_LEVEL.
- rd_en, input, 1: read request.
- rd_data, output, DATA_WIDTH: read word.
- rd_valid, output, 1: rd_data is valid (meaning depends on SHOWAHEAD).
- empty, output, 1: no stored entry.
- almost_empty, output, 1: level <= AE_LEVEL.
- level, output, $clog2(DEPTH+1): current number of stored entries.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.

Behaviour:
- Reset (reset=1 at a clock edge) sets:
  - write pointer, read pointer and level to 0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - rd_valid=0, overflow=0, underflow=0
  - rd_data to 0 in registered mode (it is don't-care in show-ahead mode)
  - Memory contents are not cleared.
- flush behaves exactly like reset, with priority over wr_en and rd_en in the same cycle; reset has priority over flush.
- Accept rules:
  - wr_acc = wr_en && !full
  - rd_acc = rd_en && !empty
  - Both are evaluated on registered state, so there is no write pass-through when full and no read-through when empty.
- Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not by power-of-two truncation.
- level update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both are accepted, or when neither is.
- Flag decoding:
  - full = (level == DEPTH); empty = (level == 0).
  - almost_full and almost_empty are decoded combinationally from the registered level, so they have zero lag relative to level.
- Error flags:
  - overflow is set at the edge where wr_en && full.
  - underflow is set at the edge where rd_en && empty.
  - Both hold until reset or flush.
- Full with wr_en and rd_en both high: the read is accepted, the write is rejected, overflow is set, and level goes to DEPTH-1.
- Empty with wr_en and rd_en both high: the write is accepted, the read is rejected, underflow is set, and level goes to 1.
- Show-ahead mode (SHOWAHEAD=1):
  - rd_data = mem[rd_ptr], combinationally; rd_valid = !empty.
  - A word written at edge N is visible on rd_data, with empty=0, in the cycle after edge N.
  - rd_acc at edge M advances rd_data to the next word after edge M.
- Registered mode (SHOWAHEAD=0):
  - On rd_acc at edge M, rd_data is loaded with mem[rd_ptr] and rd_valid=1 for the cycle after edge M.
  - rd_valid=0 otherwise; rd_data holds its last value.
  - Read latency is 1 cycle from accepted rd_en.
- Memory write: mem[wr_ptr] <= wr_data on wr_acc. A same-cycle read of the same address is impossible, because that slot is empty.
- Write-to-read latency (wr_acc to the word being readable): 1 cycle in both modes.

Test Plan:
- DEPTH=5, SHOWAHEAD=1: after reset, write 0x11..0x55 back-to-back.
  - full=1 after the 5th edge; level=5; almost_full=1 from level 4 (AF_LEVEL=4).
  - Reads return 0x11,0x22,0x33,0x44,0x55 in order, then empty=1 and level=0.
- Wrap, DEPTH=5: write 3, read 3, then write 5 words 0xA0..0xA4 (pointers wrap at 4 to 0).
  - Read order is 0xA0..0xA4 with no loss; full asserts exactly at level 5.
- Simultaneous events:
  - FIFO full plus wr_en=rd_en=1: level goes 5 to 4, the head word is dequeued, the new word is dropped, overflow=1.
  - FIFO empty plus wr_en=rd_en=1: level goes 0 to 1, underflow=1, and the written word is readable next cycle.
- SHOWAHEAD=0: write 0x1234, then pulse rd_en for one cycle.
  - rd_valid=1 and rd_data=0x1234 exactly one cycle later; rd_valid=0 in the following cycle.
  - rd_en while empty leaves rd_valid=0 and sets underflow=1.
- Flush mid-operation: level=3 with sticky overflow=1; assert flush together with wr_en=1.
  - Next cycle: level=0, empty=1, overflow=0, the write is ignored, and the next written word is the first one read.
- Reset mid-stream: assert reset while streaming writes and reads.
  - All outputs reach their reset values after one edge.
  - Operation resumes correctly on the cycle after reset deasserts.

Source files
------------

// File: rtl/sync_fifo_ex.sv
// sync_fifo_ex: single-clock FIFO, arbitrary depth, programmable thresholds, flush, sticky errors, show-ahead or registered read
module sync_fifo_ex #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int SHOWAHEAD  = 1,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid, r_overflow, r_underflow;
  logic                  w_wr_acc, w_rd_acc;
  always_comb begin
    full         = r_level == LW'(DEPTH);
    empty        = r_level == '0;
    almost_full  = r_level >= LW'(AF_LEVEL);
    almost_empty = r_level <= LW'(AE_LEVEL);
    level        = r_level;
    overflow     = r_overflow;
    underflow    = r_underflow;
    w_wr_acc     = wr_en && !full;
    w_rd_acc     = rd_en && !empty;
    rd_data      = SHOWAHEAD != 0 ? r_mem[r_rd_ptr] : r_rd_data;
    rd_valid     = SHOWAHEAD != 0 ? !empty : r_rd_valid;
  end
  // memory is deliberately left uncleared by reset and flush
  always_ff @(posedge clk)
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr == PW'(DEPTH - 1) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr == PW'(DEPTH - 1) ? '0 : r_rd_ptr + 1'b1;
      if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
      r_level     <= w_wr_acc && !w_rd_acc ? r_level + 1'b1 :
                     w_rd_acc && !w_wr_acc ? r_level - 1'b1 : r_level;
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= r_overflow || (wr_en && full);
      r_underflow <= r_underflow || (rd_en && empty);
    end
  end
endmodule

// File: tb/tb_sync_fifo_ex.sv
// tb_sync_fifo_ex: directed tests of a DEPTH=5 show-ahead FIFO and a DEPTH=4 registered-read FIFO
module tb_sync_fifo_ex;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  logic a_reset = 1'b0, a_flush = 1'b0, a_wr = 1'b0, a_re = 1'b0;
  logic [15:0] a_wd = '0, a_rd;
  logic a_full, a_af, a_rv, a_empty, a_ae, a_ovf, a_unf;
  logic [2:0] a_level;
  logic b_reset = 1'b0, b_flush = 1'b0, b_wr = 1'b0, b_re = 1'b0;
  logic [15:0] b_wd = '0, b_rd;
  logic b_full, b_af, b_rv, b_empty, b_ae, b_ovf, b_unf;
  logic [2:0] b_level;
  sync_fifo_ex #(.DEPTH(5), .DATA_WIDTH(16), .SHOWAHEAD(1)) u_a (
    .clk(clk), .reset(a_reset), .flush(a_flush), .wr_data(a_wd), .wr_en(a_wr),
    .full(a_full), .almost_full(a_af), .rd_en(a_re), .rd_data(a_rd), .rd_valid(a_rv),
    .empty(a_empty), .almost_empty(a_ae), .level(a_level), .overflow(a_ovf), .underflow(a_unf));
  sync_fifo_ex #(.DEPTH(4), .DATA_WIDTH(16), .SHOWAHEAD(0)) u_b (
    .clk(clk), .reset(b_reset), .flush(b_flush), .wr_data(b_wd), .wr_en(b_wr),
    .full(b_full), .almost_full(b_af), .rd_en(b_re), .rd_data(b_rd), .rd_valid(b_rv),
    .empty(b_empty), .almost_empty(b_ae), .level(b_level), .overflow(b_ovf), .underflow(b_unf));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    a_reset = 1'b1; b_reset = 1'b1;
    tick;
    a_reset = 1'b0; b_reset = 1'b0;
    n_tests++; if ({a_level, a_empty, a_full, a_ae, a_af, a_rv, a_ovf, a_unf} !== 10'b000_1010000) begin n_fail++; $display("FAIL reset_a got lvl=%0d e=%b f=%b ae=%b af=%b rv=%b ov=%b un=%b exp 0 1 0 1 0 0 0 0", a_level, a_empty, a_full, a_ae, a_af, a_rv, a_ovf, a_unf); end
    n_tests++; if ({b_level, b_empty, b_full, b_rv, b_ovf, b_unf} !== 8'b000_10000) begin n_fail++; $display("FAIL reset_b got lvl=%0d e=%b f=%b rv=%b ov=%b un=%b exp 0 1 0 0 0 0", b_level, b_empty, b_full, b_rv, b_ovf, b_unf); end
    n_tests++; if (b_rd !== 16'h0) begin n_fail++; $display("FAIL reset_b_rd got %h exp 0000", b_rd); end
  endtask
  task automatic test_fill;
    a_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_wd = 16'(17 * (i + 1));
      tick;
      n_tests++; if ({a_level, a_af, a_full} !== {3'(i + 1), i >= 3, i == 4}) begin n_fail++; $display("FAIL fill_%0d got lvl=%0d af=%b f=%b exp lvl=%0d af=%b f=%b", i, a_level, a_af, a_full, i + 1, i >= 3, i == 4); end
    end
    a_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (a_rd !== 16'(17 * (i + 1)) || !a_rv) begin n_fail++; $display("FAIL drain_%0d got %h rv=%b exp %h rv=1", i, a_rd, a_rv, 16'(17 * (i + 1))); end
      a_re = 1'b1;
      tick;
    end
    a_re = 1'b0;
    n_tests++; if ({a_empty, a_level, a_rv} !== 5'b1_000_0) begin n_fail++; $display("FAIL drain_end got e=%b lvl=%0d rv=%b exp 1 0 0", a_empty, a_level, a_rv); end
  endtask
  task automatic test_wrap;
    a_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin a_wd = 16'(i + 1); tick; end
    a_wr = 1'b0; a_re = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    a_re = 1'b0; a_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_wd = 16'h00A0 + 16'(i);
      tick;
      n_tests++; if ({a_full, a_level} !== {i == 4, 3'(i + 1)}) begin n_fail++; $display("FAIL wrap_fill_%0d got f=%b lvl=%0d exp f=%b lvl=%0d", i, a_full, a_level, i == 4, i + 1); end
    end
    a_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (a_rd !== 16'h00A0 + 16'(i)) begin n_fail++; $display("FAIL wrap_rd_%0d got %h exp %h", i, a_rd, 16'h00A0 + 16'(i)); end
      a_re = 1'b1;
      tick;
    end
    a_re = 1'b0;
    n_tests++; if (!a_empty) begin n_fail++; $display("FAIL wrap_empty got e=%b exp 1", a_empty); end
  endtask
  task automatic test_simul_full;
    a_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin a_wd = 16'h00B0 + 16'(i); tick; end
    a_re = 1'b1; a_wd = 16'h00EE;
    tick;
    a_wr = 1'b0; a_re = 1'b0;
    n_tests++; if ({a_level, a_ovf, a_full} !== 5'b100_1_0) begin n_fail++; $display("FAIL simul_full got lvl=%0d ov=%b f=%b exp 4 1 0", a_level, a_ovf, a_full); end
    for (int i = 1; i < 5; i++) begin
      n_tests++; if (a_rd !== 16'h00B0 + 16'(i)) begin n_fail++; $display("FAIL simul_full_rd_%0d got %h exp %h", i, a_rd, 16'h00B0 + 16'(i)); end
      a_re = 1'b1;
      tick;
    end
    a_re = 1'b0;
    n_tests++; if ({a_empty, a_unf} !== 2'b10) begin n_fail++; $display("FAIL simul_full_drop got e=%b un=%b exp 1 0", a_empty, a_unf); end
  endtask
  task automatic test_simul_empty;
    a_wr = 1'b1; a_re = 1'b1; a_wd = 16'h0077;
    tick;
    a_wr = 1'b0; a_re = 1'b0;
    n_tests++; if ({a_level, a_unf, a_ovf, a_rv} !== 6'b001_1_1_1) begin n_fail++; $display("FAIL simul_empty got lvl=%0d un=%b ov=%b rv=%b exp 1 1 1 1", a_level, a_unf, a_ovf, a_rv); end
    n_tests++; if (a_rd !== 16'h0077) begin n_fail++; $display("FAIL simul_empty_rd got %h exp 0077", a_rd); end
  endtask
  task automatic test_flush;
    a_wr = 1'b1;
    a_wd = 16'h0001; tick;
    a_wd = 16'h0002; tick;
    a_wr = 1'b0;
    n_tests++; if ({a_level, a_ovf} !== 4'b011_1) begin n_fail++; $display("FAIL pre_flush got lvl=%0d ov=%b exp 3 1", a_level, a_ovf); end
    a_flush = 1'b1; a_wr = 1'b1; a_wd = 16'h0099;
    tick;
    a_flush = 1'b0; a_wr = 1'b0;
    n_tests++; if ({a_level, a_empty, a_ovf, a_unf, a_ae} !== 7'b000_1_0_0_1) begin n_fail++; $display("FAIL flush got lvl=%0d e=%b ov=%b un=%b ae=%b exp 0 1 0 0 1", a_level, a_empty, a_ovf, a_unf, a_ae); end
    a_wr = 1'b1; a_wd = 16'h005A;
    tick;
    a_wr = 1'b0;
    n_tests++; if (a_rd !== 16'h005A || a_level !== 3'd1) begin n_fail++; $display("FAIL post_flush got %h lvl=%0d exp 005a lvl=1", a_rd, a_level); end
  endtask
  task automatic test_reset_mid;
    a_wr = 1'b1; a_wd = 16'h0061; tick;
    a_re = 1'b1; a_wd = 16'h0062; tick;
    n_tests++; if (a_level !== 3'd2) begin n_fail++; $display("FAIL stream got lvl=%0d exp 2", a_level); end
    a_reset = 1'b1;
    tick;
    a_reset = 1'b0; a_wr = 1'b0; a_re = 1'b0;
    n_tests++; if ({a_level, a_empty, a_full, a_ae, a_af, a_rv, a_ovf, a_unf} !== 10'b000_1010000) begin n_fail++; $display("FAIL reset_mid got lvl=%0d e=%b f=%b ae=%b af=%b rv=%b ov=%b un=%b exp 0 1 0 1 0 0 0 0", a_level, a_empty, a_full, a_ae, a_af, a_rv, a_ovf, a_unf); end
    a_wr = 1'b1; a_wd = 16'h0042;
    tick;
    a_wr = 1'b0;
    n_tests++; if (a_rd !== 16'h0042 || a_level !== 3'd1) begin n_fail++; $display("FAIL resume got %h lvl=%0d exp 0042 lvl=1", a_rd, a_level); end
    a_re = 1'b1;
    tick;
    a_re = 1'b0;
    n_tests++; if (!a_empty || a_unf) begin n_fail++; $display("FAIL resume_drain got e=%b un=%b exp 1 0", a_empty, a_unf); end
  endtask
  task automatic test_registered;
    b_wr = 1'b1; b_wd = 16'h1234;
    tick;
    b_wr = 1'b0;
    n_tests++; if ({b_rv, b_level, b_empty} !== 5'b0_001_0) begin n_fail++; $display("FAIL reg_wr got rv=%b lvl=%0d e=%b exp 0 1 0", b_rv, b_level, b_empty); end
    b_re = 1'b1;
    tick;
    b_re = 1'b0;
    n_tests++; if (!b_rv || b_rd !== 16'h1234 || !b_empty) begin n_fail++; $display("FAIL reg_rd got rv=%b %h e=%b exp 1 1234 1", b_rv, b_rd, b_empty); end
    tick;
    n_tests++; if (b_rv || b_rd !== 16'h1234) begin n_fail++; $display("FAIL reg_hold got rv=%b %h exp 0 1234", b_rv, b_rd); end
    b_re = 1'b1;
    tick;
    b_re = 1'b0;
    n_tests++; if (b_rv || !b_unf || b_ovf) begin n_fail++; $display("FAIL reg_underflow got rv=%b un=%b ov=%b exp 0 1 0", b_rv, b_unf, b_ovf); end
  endtask
  initial begin
    test_reset;
    test_fill;
    test_wrap;
    test_simul_full;
    test_simul_empty;
    test_flush;
    test_reset_mid;
    test_registered;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
